// File: rtl/ir_scan_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : ir_scan_seq_if
// Purpose  : A2D converter handshake bundle (strt_cnv/chnnl/cnv_cmplt/res).
// Revision : 1.0 - initial release
// ============================================================================
interface ir_scan_seq_if #(
  parameter int CH_W  = 3,
  parameter int RES_W = 12
);
  logic             strt_cnv;
  logic [CH_W-1:0]  chnnl;
  logic             cnv_cmplt;
  logic [RES_W-1:0] res;

  modport master (output strt_cnv, output chnnl, input cnv_cmplt, input res);
  modport slave  (input strt_cnv, input chnnl, output cnv_cmplt, output res);
endinterface
`default_nettype wire

// File: rtl/ir_scan_seq.sv
`default_nettype none
// ============================================================================
// Module   : ir_scan_seq
// Purpose  : IR sensor scan sequencer; converts NUM_CH channels per round via
//            the A2D handshake, stores results and tracks the maximum reading.
//            Optional macro IR_OVERSAMPLE_EN: two conversions per channel,
//            averaged.
// Revision : 1.0 - initial release
// ============================================================================
module ir_scan_seq #(
  parameter int               NUM_CH     = 8,
  parameter int               RES_W      = 12,
  parameter int               PERIOD_W   = 18,
  parameter int               SETTLE_W   = 12,
  parameter logic [RES_W-1:0] LINE_THRES = 'h040,
  localparam int              CH_W       = $clog2(NUM_CH)
) (
  input  wire logic                    clk,
  input  wire logic                    rst_n,
  input  wire logic                    i_en,
  ir_scan_seq_if.master                a2d,
  output logic                         o_IR_en,
  output logic                         o_IR_vld,
  output logic                         o_line_present,
  output logic [NUM_CH*RES_W-1:0]      o_IR_vals,
  output logic [RES_W-1:0]             o_IR_max,
  output logic [CH_W-1:0]              o_max_ch
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WAIT_TMR = 3'd1,
    S_SETTLE   = 3'd2,
    S_START    = 3'd3,
    S_WAIT_CNV = 3'd4,
    S_DONE     = 3'd5
  } state_t;

  state_t                        r_state;
  state_t                        w_state_nxt;
  logic [PERIOD_W-1:0]           r_tmr;
  logic [CH_W-1:0]               r_chnnl;
  logic [NUM_CH-1:0][RES_W-1:0]  r_ir_vals;
  logic [RES_W-1:0]              r_ir_max;
  logic [CH_W-1:0]               r_max_ch;
  logic                          r_line_present;

  logic             w_strt;
  logic             w_ir_en;
  logic             w_ir_vld;
  logic             w_tmr_full;
  logic             w_settled;
  logic             w_last_ch;
  logic             w_cnv_accept;
  logic             w_sample_done;
  logic             w_store;
  logic             w_tmr_clr;
  logic             w_round_start;
  logic [RES_W-1:0] w_val;

  assign w_tmr_full   = &r_tmr;
  assign w_settled    = &r_tmr[SETTLE_W-1:0];
  assign w_last_ch    = (r_chnnl == CH_W'(NUM_CH - 1));
  assign w_cnv_accept = (r_state == S_WAIT_CNV) && a2d.cnv_cmplt;
  assign w_store      = w_cnv_accept && w_sample_done;

`ifdef IR_OVERSAMPLE_EN
  // First sample of each pair is parked in r_s0; the sum keeps one extra bit.
  logic             r_phase;
  logic [RES_W-1:0] r_s0;
  logic [RES_W:0]   w_sum;

  assign w_sum         = {1'b0, r_s0} + {1'b0, a2d.res};
  assign w_val         = w_sum[RES_W:1];
  assign w_sample_done = r_phase;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase <= 1'b0;
      r_s0    <= '0;
    end else if (r_state == S_SETTLE) begin
      r_phase <= 1'b0;
    end else if (w_cnv_accept) begin
      r_phase <= ~r_phase;
      if (!r_phase) r_s0 <= a2d.res;
    end
  end
`else
  assign w_val         = a2d.res;
  assign w_sample_done = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_strt      = 1'b0;
    w_ir_en     = 1'b0;
    w_ir_vld    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_en) w_state_nxt = S_WAIT_TMR;
      end
      S_WAIT_TMR: begin
        if (!i_en)          w_state_nxt = S_IDLE;
        else if (w_tmr_full) w_state_nxt = S_SETTLE;
      end
      S_SETTLE: begin
        w_ir_en = 1'b1;
        if (!i_en)          w_state_nxt = S_IDLE;
        else if (w_settled) w_state_nxt = S_START;
      end
      S_START: begin
        w_ir_en     = 1'b1;
        w_strt      = 1'b1;
        w_state_nxt = S_WAIT_CNV;
      end
      S_WAIT_CNV: begin
        w_ir_en = 1'b1;
        // An abort only takes effect once the channel's value is stored.
        if (a2d.cnv_cmplt) begin
          if (!w_sample_done) w_state_nxt = S_START;
          else if (!i_en)     w_state_nxt = S_IDLE;
          else if (w_last_ch) w_state_nxt = S_DONE;
          else                w_state_nxt = S_START;
        end
      end
      S_DONE: begin
        w_ir_vld    = 1'b1;
        w_state_nxt = i_en ? S_WAIT_TMR : S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_tmr_clr     = (w_state_nxt != r_state) &&
                         ((w_state_nxt == S_WAIT_TMR) || (w_state_nxt == S_SETTLE));
  assign w_round_start = (r_state == S_WAIT_TMR) && (w_state_nxt == S_SETTLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tmr          <= '0;
      r_chnnl        <= '0;
      r_ir_vals      <= '0;
      r_ir_max       <= '0;
      r_max_ch       <= '0;
      r_line_present <= 1'b0;
    end else begin
      if (w_tmr_clr) r_tmr <= '0;
      else           r_tmr <= r_tmr + 1'b1;

      if ((r_state == S_SETTLE) && (w_state_nxt == S_START))
        r_chnnl <= '0;
      else if (w_store)
        r_chnnl <= (w_last_ch || !i_en) ? '0 : r_chnnl + 1'b1;

      if (w_store) r_ir_vals[r_chnnl] <= w_val;

      // Strict compare: on a tie the earlier (lower) channel keeps the max.
      if (w_round_start) begin
        r_ir_max <= '0;
        r_max_ch <= '0;
      end else if (w_store && (w_val > r_ir_max)) begin
        r_ir_max <= w_val;
        r_max_ch <= r_chnnl;
      end

      if (r_state == S_DONE) r_line_present <= (r_ir_max > LINE_THRES);
    end
  end

  assign a2d.strt_cnv   = w_strt;
  assign a2d.chnnl      = r_chnnl;
  assign o_IR_en        = w_ir_en;
  assign o_IR_vld       = w_ir_vld;
  assign o_line_present = r_line_present;
  assign o_IR_vals      = r_ir_vals;
  assign o_IR_max       = r_ir_max;
  assign o_max_ch       = r_max_ch;

endmodule
`default_nettype wire

// File: tb/tb_ir_scan_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_ir_scan_seq
// Purpose  : Directed self-checking bench for ir_scan_seq (8- and 5-channel).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ir_scan_seq;

`ifdef IR_OVERSAMPLE_EN
  localparam int          OS   = 2;
  localparam logic [11:0] EXP2 = 12'h101;
`else
  localparam int          OS   = 1;
  localparam logic [11:0] EXP2 = 12'h100;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en8, en5;
  logic        ir_en8, vld8, line8, ir_en5, vld5, line5;
  logic [95:0] vals8;
  logic [59:0] vals5;
  logic [11:0] max8, max5;
  logic [2:0]  mch8, mch5;

  logic [11:0] tbl  [8];
  logic [11:0] tbl2 [8];
  logic [11:0] tbl5 [5];
  int          strt_cnt8 = 0;
  int          vld_cnt8  = 0;
  int          seq5 [$];
  int          n_tests   = 0;
  int          n_fail    = 0;
  int          cyc;
  int          snap;

  always #5 clk = ~clk;

  ir_scan_seq_if #(.CH_W(3), .RES_W(12)) a8 ();
  ir_scan_seq_if #(.CH_W(3), .RES_W(12)) a5 ();

  ir_scan_seq #(.NUM_CH(8), .RES_W(12), .PERIOD_W(6), .SETTLE_W(3), .LINE_THRES(12'h040)) dut8 (
    .clk(clk), .rst_n(rst_n), .i_en(en8), .a2d(a8.master),
    .o_IR_en(ir_en8), .o_IR_vld(vld8), .o_line_present(line8),
    .o_IR_vals(vals8), .o_IR_max(max8), .o_max_ch(mch8));

  ir_scan_seq #(.NUM_CH(5), .RES_W(12), .PERIOD_W(6), .SETTLE_W(3), .LINE_THRES(12'h040)) dut5 (
    .clk(clk), .rst_n(rst_n), .i_en(en5), .a2d(a5.master),
    .o_IR_en(ir_en5), .o_IR_vld(vld5), .o_line_present(line5),
    .o_IR_vals(vals5), .o_IR_max(max5), .o_max_ch(mch5));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // A2D model for the 8-channel DUT: 3-cycle conversion latency.
  initial begin : model8
    logic [2:0] ch;
    bit         second;
    second       = 1'b0;
    a8.cnv_cmplt = 1'b0;
    a8.res       = '0;
    forever begin
      if (!(rst_n === 1'b1 && a8.strt_cnv === 1'b1)) begin
        @(posedge clk); #1;
      end else begin
        ch = a8.chnnl;
        strt_cnt8++;
        repeat (3) @(posedge clk);
        #1;
        chk("chnnl_stable8", 64'(a8.chnnl), 64'(ch));
        a8.res = (OS == 2 && second) ? tbl2[ch] : tbl[ch];
        if (OS == 2) second = !second;
        a8.cnv_cmplt = 1'b1;
        @(posedge clk); #1;
        a8.cnv_cmplt = 1'b0;
      end
    end
  end

  initial begin : model5
    logic [2:0] ch;
    a5.cnv_cmplt = 1'b0;
    a5.res       = '0;
    forever begin
      if (!(rst_n === 1'b1 && a5.strt_cnv === 1'b1)) begin
        @(posedge clk); #1;
      end else begin
        ch = a5.chnnl;
        seq5.push_back(int'(ch));
        repeat (3) @(posedge clk);
        #1;
        a5.res       = (ch < 3'd5) ? tbl5[ch] : 12'hfff;
        a5.cnv_cmplt = 1'b1;
        @(posedge clk); #1;
        a5.cnv_cmplt = 1'b0;
      end
    end
  end

  initial begin : vld_mon
    forever begin
      @(posedge clk); #1;
      if (vld8 === 1'b1) vld_cnt8++;
    end
  end

  task automatic wait_vld8(input string tag);
    int n;
    n = 0;
    while (vld8 !== 1'b1 && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    if (vld8 !== 1'b1) chk(tag, 64'(vld8), 64'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0;
    en8   = 1'b0;
    en5   = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tbl[k]  = 12'(16 * (k + 1));
      tbl2[k] = 12'(16 * (k + 1));
    end
    tbl5[0] = 12'h020; tbl5[1] = 12'h070; tbl5[2] = 12'h050;
    tbl5[3] = 12'h070; tbl5[4] = 12'h010;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ir_en",  64'(ir_en8), 64'd0);
    chk("rst_strt",   64'(a8.strt_cnv), 64'd0);
    chk("rst_vld",    64'(vld8), 64'd0);
    chk("rst_line",   64'(line8), 64'd0);
    chk("rst_max",    64'(max8), 64'd0);
    chk("rst_max_ch", 64'(mch8), 64'd0);
    chk("rst_vals",   64'(vals8[63:0]), 64'd0);
    chk("rst_chnnl",  64'(a8.chnnl), 64'd0);
    rst_n = 1'b1;

    // Round 1: ramp values, 64 timer + 8 settle cycles before first start.
    @(posedge clk); #1;
    en8 = 1'b1;
    @(posedge clk);
    cyc = 0;
    while (cyc < 200 && a8.strt_cnv !== 1'b1) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("first_strt_delay", 64'(cyc), 64'd72);
    wait_vld8("r1_vld_timeout");
    chk("r1_strt_cnt", 64'(strt_cnt8), 64'(8 * OS));
    chk("r1_vld_cnt",  64'(vld_cnt8), 64'd1);
    for (int k = 0; k < 8; k++)
      chk($sformatf("r1_slot%0d", k), 64'(vals8[k*12 +: 12]), 64'(16 * (k + 1)));
    chk("r1_max",    64'(max8), 64'h080);
    chk("r1_max_ch", 64'(mch8), 64'd7);
    chk("r1_line",   64'(line8), 64'd1);

    // Round 2: all channels equal, below threshold.
    for (int k = 0; k < 8; k++) begin
      tbl[k]  = 12'h030;
      tbl2[k] = 12'h030;
    end
    strt_cnt8 = 0;
    wait_vld8("r2_vld_timeout");
    chk("r2_strt_cnt", 64'(strt_cnt8), 64'(8 * OS));
    chk("r2_vld_cnt",  64'(vld_cnt8), 64'd2);
    chk("r2_max",      64'(max8), 64'h030);
    chk("r2_max_ch",   64'(mch8), 64'd0);
    chk("r2_line",     64'(line8), 64'd0);
    chk("r2_slot5",    64'(vals8[5*12 +: 12]), 64'h030);

    // Round 3: channel 2 sample pair 0x100/0x103.
    tbl[2]    = 12'h100;
    tbl2[2]   = 12'h103;
    strt_cnt8 = 0;
    wait_vld8("r3_vld_timeout");
    chk("r3_strt_cnt", 64'(strt_cnt8), 64'(8 * OS));
    chk("r3_slot2",    64'(vals8[2*12 +: 12]), 64'(EXP2));
    chk("r3_max",      64'(max8), 64'(EXP2));
    chk("r3_max_ch",   64'(mch8), 64'd2);
    chk("r3_line",     64'(line8), 64'd1);

    // Round 4: abort while channel 3 converts.
    tbl[3]  = 12'h055;
    tbl2[3] = 12'h055;
    cyc = 0;
    while (cyc < 300 && !(a8.strt_cnv === 1'b1 && a8.chnnl === 3'd3)) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("ab_reach_ch3", 64'(a8.chnnl), 64'd3);
    en8 = 1'b0;
    cyc = 0;
    while (cyc < 50 && ir_en8 !== 1'b0) begin
      @(posedge clk); #1;
      cyc++;
    end
    snap = strt_cnt8;
    repeat (100) @(posedge clk);
    #1;
    chk("ab_ir_en",    64'(ir_en8), 64'd0);
    chk("ab_no_strt",  64'(strt_cnt8), 64'(snap));
    chk("ab_vld_cnt",  64'(vld_cnt8), 64'd3);
    chk("ab_line",     64'(line8), 64'd1);
    chk("ab_slot3",    64'(vals8[3*12 +: 12]), 64'h055);
    chk("ab_slot4",    64'(vals8[4*12 +: 12]), 64'h030);
    chk("ab_max",      64'(max8), 64'(EXP2));
    chk("ab_chnnl",    64'(a8.chnnl), 64'd0);

    // Asynchronous reset while the emitters are on.
    en8 = 1'b1;
    cyc = 0;
    while (cyc < 200 && ir_en8 !== 1'b1) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("rs_settle_ir_en", 64'(ir_en8), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rs_ir_en", 64'(ir_en8), 64'd0);
    chk("rs_strt",  64'(a8.strt_cnv), 64'd0);
    chk("rs_max",   64'(max8), 64'd0);
    chk("rs_line",  64'(line8), 64'd0);
    chk("rs_vals",  64'(vals8[95:32]), 64'd0);
    en8 = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Five-channel instance: channel wrap and tie handling.
    @(posedge clk); #1;
    en5 = 1'b1;
    cyc = 0;
    while (cyc < 400 && vld5 !== 1'b1) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("c5_vld",       64'(vld5), 64'd1);
    chk("c5_chnnl_end", 64'(a5.chnnl), 64'd0);
    en5 = 1'b0;
    @(posedge clk); #1;
    chk("c5_seq_len", 64'(seq5.size()), 64'(5 * OS));
    for (int i = 0; i < seq5.size(); i++)
      chk($sformatf("c5_seq%0d", i), 64'(seq5[i]), 64'(i / OS));
    for (int k = 0; k < 5; k++)
      chk($sformatf("c5_slot%0d", k), 64'(vals5[k*12 +: 12]), 64'(tbl5[k]));
    chk("c5_max",    64'(max5), 64'h070);
    chk("c5_max_ch", 64'(mch5), 64'd1);
    chk("c5_line",   64'(line5), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ir_scan_seq.md
Name: ir_scan_seq

Overview:
Parametrised IR sensor scan sequencer that drives an external A2D converter through a strt_cnv/cnv_cmplt/res handshake.
- Periodically enables the IR emitters and waits a settle time.
- Converts NUM_CH channels in order, 0 to NUM_CH-1, and stores each result.
- Tracks the maximum reading and its channel index, and derives line_present.
- Sits between the A2D interface and the line-follow/steering logic. Supports arbitrary channel counts, an enable/abort control and max-channel reporting.

Parameters:
NUM_CH, 8, number of IR channels scanned per round (2..16)
RES_W, 12, A2D result width
CH_W, $clog2(NUM_CH), channel index width (derived localparam)
PERIOD_W, 18, round timer width; round starts when the timer is all ones
SETTLE_W, 12, settle timer width; settled when the low SETTLE_W bits are all ones
LINE_THRES, 'h040, line_present threshold (RES_W bits)

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
en  in  1  scan enable
strt_cnv  out  1  one-cycle A2D start pulse
chnnl  out  CH_W  channel index presented to the A2D
cnv_cmplt  in  1  A2D conversion done, one-cycle pulse
res  in  RES_W  A2D result, valid while cnv_cmplt is high
IR_en  out  1  IR emitter enable
IR_vld  out  1  one-cycle pulse: full round stored
line_present  out  1  IR_max > LINE_THRES at the last completed round
IR_vals  out  NUM_CH*RES_W  stored results; channel k occupies bits [k*RES_W +: RES_W]
IR_max  out  RES_W  largest result of the last/current round
max_ch  out  CH_W  channel index of IR_max

Behaviour:
- Reset values: state IDLE; all outputs 0; both timers 0.
- Single free-running timer tmr[PERIOD_W-1:0]. It is cleared on every state transition into WAIT_TMR or SETTLE and increments otherwise.
- IDLE: IR_en=0. Moves to WAIT_TMR when en=1, with tmr cleared.
- WAIT_TMR: when tmr is all ones, move to SETTLE, clear tmr, clear IR_max/max_ch to 0. If en=0, go to IDLE.
- SETTLE: IR_en=1. When tmr[SETTLE_W-1:0] is all ones, move to START with chnnl=0. If en=0, go to IDLE with IR_en=0 next cycle.
- START: IR_en=1, strt_cnv=1 for exactly one cycle, then go to WAIT_CNV.
- WAIT_CNV: IR_en=1 and chnnl is held stable. On cnv_cmplt:
  - Write res into slot chnnl the same edge.
  - If res > IR_max (strict), load IR_max=res and max_ch=chnnl. On ties the lower index wins.
  - If chnnl==NUM_CH-1: go to DONE and set chnnl=0. Otherwise increment chnnl and go to START.
  - chnnl never reaches values >= NUM_CH, including for non-power-of-two NUM_CH.
- DONE: IR_vld=1 for one cycle, IR_en=0. line_present is registered on this edge from IR_max > LINE_THRES. Next state is WAIT_TMR if en=1, else IDLE.
- IR_vals, IR_max, max_ch and line_present hold their values between rounds. IR_max may be cleared at round start (WAIT_TMR to SETTLE). line_present changes only in DONE.
- en deasserted in START/WAIT_CNV: the in-flight conversion completes and is stored, then the block goes to IDLE. No IR_vld; line_present is unchanged.
- cnv_cmplt outside WAIT_CNV is ignored.
- Reset mid-scan: immediate return to reset values; strt_cnv and IR_en go low asynchronously.
- All logic is synchronous to clk; no derived clocks.

Optional Feature:
IR_OVERSAMPLE_EN.
- Defined: each channel is converted twice back-to-back (START, WAIT_CNV, START, WAIT_CNV) with the same chnnl. The first sample is held internally. The stored and max-compared value is (s0+s1)>>1, using an RES_W+1-bit sum so there is no overflow. strt_cnv pulses 2*NUM_CH times per round.
- Undefined: one conversion per channel as described above.

Test Plan:
- PERIOD_W=6, SETTLE_W=3, en=1, A2D model returns 'h010*(k+1) for channel k:
  - IR_vld pulses once after 8 conversions; IR_vals slot k = 'h010*(k+1).
  - IR_max='h080, max_ch=7, line_present=1.
- All channels return 'h030: IR_max='h030, max_ch=0 (tie keeps lowest index), line_present=0.
- Check round timing: strt_cnv count per round = NUM_CH; chnnl stable from START through cnv_cmplt; first strt_cnv occurs exactly 64+8 cycles after entering WAIT_TMR.
- NUM_CH=5: chnnl sequence 0,1,2,3,4,0; never 5-7; IR_vals width 60.
- Deassert en during WAIT_CNV on channel 3: slot 3 is stored, no IR_vld, state goes to IDLE, IR_en=0, line_present is held.
- With IR_OVERSAMPLE_EN and samples 'h100/'h103 on channel 2: slot 2 = 'h101; strt_cnv count = 16 per round.
